signmag_normalizer: RTL and testbench
=====================================

// Module: signmag_normalizer
// PURPOSE
// - Inverse of the two-input sign-magnitude adder. Takes its W-bit two's-complement sum,
//   W = sigWidth+4+low_expand, and returns sign-magnitude form for repacking into the
//   hadamard/FFT float format.
// - Output is sign, a left-normalised mantissa and a leading-zero count for the exponent path.
// - Two-stage pipeline with valid/ready flow control on both sides.
// PARAMETERS
// - sigWidth    4  fraction bits of the packed format; mant_out is sigWidth+1 bits wide
// - low_expand  2  extra low-order bits the adder path carries
// - (derived) W = sigWidth+4+low_expand; LW = $clog2(W+1)
// PORTS
// - clk        in   1          rising-edge clock; the block has one clock
// - rst        in   1          synchronous, active-high reset
// - in_valid   in   1          sum_in is valid
// - in_ready   out  1          block accepts sum_in this cycle
// - sum_in     in   W          two's-complement sum
// - out_valid  out  1          result valid
// - out_ready  in   1          consumer takes the result this cycle
// - sign_out   out  1          1 = negative
// - zero_out   out  1          sum was exactly 0
// - lzc_out    out  LW         leading zeros of |sum| within W bits (W when zero)
// - mant_out   out  sigWidth+1 top bits of the normalised magnitude; MSB is the hidden 1
// - rnd_carry  out  1          rounding overflowed; mant_out = 100..0, exponent path adds 1
// BEHAVIOUR
// - Reset: all valids, all outputs and all pipeline registers go to 0 on the next edge.
//   In-flight data is discarded. in_ready is 1 in the first cycle after rst is released.
// - Handshake: a transfer happens when valid && ready. Data holds stable while valid && !ready.
// - Stage S1 (register s1) on accept:
//   - sign = sum_in[W-1]
//   - mag = sign ? (~sum_in + 1) : sum_in, computed W bits wide and unsigned.
//     -2^(W-1) gives mag = 100..0, which is legal.
//   - zero = (sum_in == 0). Zero forces sign = 0, so no negative zero.
// - Stage S2 (output register):
//   - lzc = count of leading zeros of mag.
//   - norm = mag << lzc; norm[W-1] = 1 unless zero.
//   - mant = norm[W-1 -: sigWidth+1].
// - Flow control:
//   - adv2 = !out_valid || out_ready
//   - adv1 = !s1_valid || adv2
//   - in_ready = adv1
//   - Both stages advance together when adv2 is set.
//   - A bubble in S1 can still be filled while S2 is stalled.
// - Latency: 2 cycles from accept to out_valid with no stall.
// - Throughput: 1 result per cycle.
// - Capacity: at most 2 results in flight. With out_ready=0 the block fills S1 and S2,
//   then drops in_ready. No loss, no reordering.
// - Simultaneous accept in and take out on a full pipe: legal; pipe stays full.
// - Zero input: lzc_out = W, mant_out = 0, zero_out = 1, rnd_carry = 0.
// CONFIGURATION
// - Macro SIGNMAG_NORM_ROUND_EN.
// - Defined: mant_out is rounded to nearest, ties to even.
//   - guard = norm[W-sigWidth-2]; sticky = OR of the bits below guard.
//   - Rounding is computed inside S2; latency is unchanged.
//   - If rounding carries out: mant_out = 1 followed by zeros, rnd_carry = 1, lzc_out unchanged.
// - Undefined: mant_out is truncated and rnd_carry is tied to 0.
// TESTING (sigWidth=4, low_expand=2, W=10, LW=4)
// - sum_in=10'h005, out_ready=1 -> 2 cycles later: sign 0, zero 0, lzc 7, mant 5'b10100.
// - sum_in=10'h3FB (-5) -> sign 1, lzc 7, mant 5'b10100. sum_in=10'h200 (-512) -> sign 1,
//   lzc 0, mant 5'b10000. sum_in=0 -> zero 1, sign 0, lzc 10, mant 0.
// - sum_in=10'h03F (63):
//   - ROUND_EN defined: mant 5'b10000, rnd_carry 1, lzc 4.
//   - ROUND_EN undefined: mant 5'b11111, rnd_carry 0.
// - sum_in=10'h037 (55) with ROUND_EN defined: tie case, odd LSB -> mant 5'b11100, rnd_carry 0.
// - out_ready=0, stream 3 inputs -> 2 accepted, then in_ready=0. Raise out_ready: results come
//   out in order, one per cycle, and the 3rd input is accepted.
// - Assert rst with 2 results in flight -> next cycle out_valid=0, all outputs 0.
//   A new input after release appears exactly 2 cycles later.

Source files
------------

// File: rtl/signmag_normalizer.sv
// Converts a two's-complement sum into sign, left-normalised mantissa and leading-zero count.
// Two-stage valid/ready pipeline; define SIGNMAG_NORM_ROUND_EN for round-to-nearest-even mantissa.
module signmag_normalizer #(
    parameter int sig_width  = 4,
    parameter int low_expand = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [sig_width+low_expand+3:0] sum_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          sign_out,
    output logic                          zero_out,
    output logic [$clog2(sig_width+low_expand+5)-1:0] lzc_out,
    output logic [sig_width:0]            mant_out,
    output logic                          rnd_carry
);

    localparam int W  = sig_width + 4 + low_expand;
    localparam int LW = $clog2(W + 1);
    localparam int MW = sig_width + 1;

    logic          adv1, adv2;
    logic          s1_valid, s1_sign, s1_zero;
    logic [W-1:0]  s1_mag;
    logic [LW-1:0] lzc;
    logic [MW-1:0] mant_trunc, mant_fin;
    logic          carry_fin;

    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;

    // S1 may refill a bubble even while S2 is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_mag   <= '0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= sum_in[W-1];
                s1_zero <= (sum_in == '0);
                s1_mag  <= sum_in[W-1] ? (~sum_in + W'(1)) : sum_in;
            end
        end
    end

    always_comb begin
        lzc = LW'(W);
        for (int i = 0; i < W; i++) begin
            if (s1_mag[i]) lzc = LW'(W - 1 - i);
        end
    end

`ifdef SIGNMAG_NORM_ROUND_EN
    localparam int GB = W - MW - 1;

    logic [W-1:0] norm;
    logic         guard, sticky, round_up;
    logic [MW:0]  mant_sum;

    assign norm       = s1_mag << lzc;
    assign mant_trunc = norm[W-1 -: MW];
    assign guard      = norm[GB];
    assign sticky     = |norm[GB-1:0];
    assign round_up   = guard && (sticky || mant_trunc[0]);
    assign mant_sum   = {1'b0, mant_trunc} + {{MW{1'b0}}, round_up};

    // A carry out of an all-ones mantissa wraps to 1.000 and bumps the exponent downstream.
    always_comb begin
        mant_fin  = mant_sum[MW-1:0];
        carry_fin = 1'b0;
        if (mant_sum[MW]) begin
            mant_fin  = {1'b1, {sig_width{1'b0}}};
            carry_fin = 1'b1;
        end
    end
`else
    assign mant_trunc = MW'((s1_mag << lzc) >> (W - MW));
    assign mant_fin   = mant_trunc;
    assign carry_fin  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sign_out  <= 1'b0;
            zero_out  <= 1'b0;
            lzc_out   <= '0;
            mant_out  <= '0;
            rnd_carry <= 1'b0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sign_out  <= s1_sign;
                zero_out  <= s1_zero;
                lzc_out   <= lzc;
                mant_out  <= mant_fin;
                rnd_carry <= carry_fin;
            end
        end
    end

endmodule

// File: tb/tb_signmag_normalizer.sv
// Self-checking bench for signmag_normalizer: arithmetic reference model plus scoreboard,
// directed vectors, stall/capacity, reset-in-flight and random back-pressure.
module tb_signmag_normalizer;

    localparam int SW = 4;
    localparam int LE = 2;
    localparam int W  = SW + 4 + LE;
    localparam int LW = $clog2(W + 1);
    localparam int MW = SW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  sum_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          sign_out, zero_out, rnd_carry;
    logic [LW-1:0] lzc_out;
    logic [MW-1:0] mant_out;

    always #5 clk = ~clk;

    signmag_normalizer #(.sig_width(SW), .low_expand(LE)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .sum_in(sum_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .sign_out(sign_out), .zero_out(zero_out), .lzc_out(lzc_out),
        .mant_out(mant_out), .rnd_carry(rnd_carry)
    );

    typedef struct {
        int sign;
        int zero;
        int lzc;
        int mant;
        int carry;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   accepts = 0;
    int   outputs = 0;
    bit   rand_rdy = 0;
    bit   prev_stall = 0;
    int   prev_mant, prev_lzc, prev_sign;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: signed value -> magnitude -> smallest shift that sets the top bit.
    function automatic exp_t model(input logic [W-1:0] s);
        exp_t e;
        int   v, mag, k, shifted, m, rem, half;
        v = s[W-1] ? int'(s) - (1 << W) : int'(s);
        mag = (v < 0) ? -v : v;
        e.sign  = (v < 0) ? 1 : 0;
        e.zero  = (mag == 0) ? 1 : 0;
        e.carry = 0;
        if (mag == 0) begin
            k = W;
            shifted = 0;
        end else begin
            k = 0;
            while (mag * (1 << k) < (1 << (W - 1))) k++;
            shifted = mag * (1 << k);
        end
        m    = shifted / (1 << (W - MW));
        rem  = shifted % (1 << (W - MW));
        half = 1 << (W - MW - 1);
`ifdef SIGNMAG_NORM_ROUND_EN
        if (rem > half || (rem == half && (m % 2) == 1)) m++;
        if (m == (1 << MW)) begin
            m = 1 << SW;
            e.carry = 1;
        end
`else
        if (rem < 0) m = 0;
`endif
        e.lzc  = k;
        e.mant = m;
        return e;
    endfunction

    // One cycle: monitor at the falling edge, then return 1ns after the rising edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (rst) begin
            q.delete();
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_mant", int'(mant_out), prev_mant);
                chk("hold_lzc", int'(lzc_out), prev_lzc);
                chk("hold_sign", int'(sign_out), prev_sign);
            end
            prev_stall = out_valid && !out_ready;
            prev_mant  = int'(mant_out);
            prev_lzc   = int'(lzc_out);
            prev_sign  = int'(sign_out);
            if (out_valid && out_ready) begin
                outputs++;
                if (q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("sign", int'(sign_out), e.sign);
                    chk("zero", int'(zero_out), e.zero);
                    chk("lzc", int'(lzc_out), e.lzc);
                    chk("mant", int'(mant_out), e.mant);
                    chk("rnd_carry", int'(rnd_carry), e.carry);
                end
            end
            if (in_valid && in_ready) begin
                accepts++;
                q.push_back(model(sum_in));
            end
        end
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [W-1:0] v);
        int n;
        in_valid = 1'b1;
        sum_in   = v;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk("send_timeout", n, 0);
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 200) begin
            step();
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    logic [W-1:0] vecs [12] = '{10'h005, 10'h3FB, 10'h200, 10'h000, 10'h03F, 10'h037,
                               10'h001, 10'h1FF, 10'h3FF, 10'h201, 10'h100, 10'h2AA};

    initial begin
        exp_t e;

        // Pin the model to hand-computed values.
        e = model(10'h005);
        chk("model_5_lzc", e.lzc, 7);   chk("model_5_mant", e.mant, 5'b10100);
        e = model(10'h3FB);
        chk("model_m5_sign", e.sign, 1); chk("model_m5_mant", e.mant, 5'b10100);
        e = model(10'h200);
        chk("model_m512_lzc", e.lzc, 0); chk("model_m512_mant", e.mant, 5'b10000);
        e = model(10'h000);
        chk("model_0_lzc", e.lzc, 10);  chk("model_0_zero", e.zero, 1);
        e = model(10'h03F);
`ifdef SIGNMAG_NORM_ROUND_EN
        chk("model_63_mant", e.mant, 5'b10000); chk("model_63_carry", e.carry, 1);
        e = model(10'h037);
        chk("model_55_mant", e.mant, 5'b11100);
`else
        chk("model_63_mant", e.mant, 5'b11111); chk("model_63_carry", e.carry, 0);
        e = model(10'h037);
        chk("model_55_mant", e.mant, 5'b11011);
`endif

        // Reset
        step();
        step();
        rst = 1'b0;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_mant", int'(mant_out), 0);
        chk("rst_lzc", int'(lzc_out), 0);
        chk("rst_in_ready", int'(in_ready), 1);

        // Latency: presented in cycle c, out_valid in cycle c+2
        in_valid = 1'b1;
        sum_in   = 10'h005;
        step();
        in_valid = 1'b0;
        chk("lat_early", int'(out_valid), 0);
        step();
        chk("lat_valid", int'(out_valid), 1);
        chk("lat_mant", int'(mant_out), 5'b10100);
        chk("lat_lzc", int'(lzc_out), 7);
        chk("lat_sign", int'(sign_out), 0);
        step();

        // Back-to-back directed vectors, full throughput
        for (int i = 0; i < 12; i++) send(vecs[i]);
        drain();
        chk("throughput_count", outputs, 13);

        // Capacity: two accepted with out_ready low, third blocked
        accepts   = 0;
        outputs   = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sum_in    = 10'h03F;
        step();
        sum_in = 10'h037;
        step();
        sum_in = 10'h3FB;
        chk("cap_in_ready_low", int'(in_ready), 0);
        step();
        chk("cap_still_low", int'(in_ready), 0);
        chk("cap_accepts", accepts, 2);
        out_ready = 1'b1;
        #1;
        chk("cap_in_ready_up", int'(in_ready), 1);
        step();
        in_valid = 1'b0;
        drain();
        chk("cap_outputs", outputs, 3);

        // Reset with two results in flight
        out_ready = 1'b0;
        send(10'h100);
        send(10'h2AA);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_out_valid", int'(out_valid), 0);
        chk("rst2_sign", int'(sign_out), 0);
        chk("rst2_lzc", int'(lzc_out), 0);
        chk("rst2_mant", int'(mant_out), 0);
        chk("rst2_in_ready", int'(in_ready), 1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        sum_in    = 10'h3FB;
        step();
        in_valid = 1'b0;
        chk("rst2_early", int'(out_valid), 0);
        step();
        chk("rst2_valid", int'(out_valid), 1);
        chk("rst2_new_sign", int'(sign_out), 1);
        chk("rst2_new_lzc", int'(lzc_out), 7);
        step();
        drain();

        // Random back-pressure over all vectors plus random sums
        rand_rdy = 1;
        for (int i = 0; i < 12; i++) send(vecs[i]);
        for (int i = 0; i < 60; i++) send(W'($urandom_range(0, (1 << W) - 1)));
        rand_rdy  = 0;
        out_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
